// File: rtl/dmem_pkg.sv
// dmem_pkg: FSM encoding, index-width helper and error causes for the
// data-memory responder and its storage array.
package dmem_pkg;

  localparam int DMEM_DEPTH   = 256;
  localparam int DMEM_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef logic [1:0] dmem_err_t;

  localparam dmem_err_t DMEM_ERR_NONE     = 2'd0;
  localparam dmem_err_t DMEM_ERR_MISALIGN = 2'd1;
  localparam dmem_err_t DMEM_ERR_RANGE    = 2'd2;

  // Word-index width for a given depth (at least one bit).
  function automatic int dmem_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DMEM_IDX_W = dmem_idx_w(DMEM_DEPTH);

  // Classify a byte address; misalignment wins over range.
  function automatic dmem_err_t dmem_cause(
    input logic [31:0] addr,
    input logic [31:0] depth
  );
    if (addr[1:0] != 2'b00) return DMEM_ERR_MISALIGN;
    if ({2'b00, addr[31:2]} >= depth) return DMEM_ERR_RANGE;
    return DMEM_ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 word storage, synchronous byte-enabled write,
// asynchronous read. Contents are never reset.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] r_mem [DEPTH];

  // Write the enabled bytes of the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) r_mem[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = r_mem[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: req/ack word RAM responder with LATENCY wait states.
// Build option DMEM_BYTE_STROBE_EN adds be_i per-byte store enables.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  be_i,
`endif
  output logic        busy_o,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);

  localparam int         IW  = dmem_idx_w(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  dmem_state_e   r_state;
  logic [3:0]    r_cnt;
  logic          r_busy;
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic          r_we;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_wdata;
  dmem_err_t     r_cause;
  logic [3:0]    r_be;

  logic          w_idle;
  dmem_err_t     w_acc_cause;
  logic [3:0]    w_acc_be;
  logic          w_we;
  dmem_err_t     w_cause;
  logic [IW-1:0] w_idx;
  logic          w_to_resp;
  logic          w_ram_we;
  logic [31:0]   w_rd;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_acc_cause = dmem_cause(addr_i, 32'(DEPTH));

`ifdef DMEM_BYTE_STROBE_EN
  assign w_acc_be = be_i;
`else
  assign w_acc_be = 4'hF;
`endif

  // In IDLE the live request feeds the RESP entry path (zero wait states).
  assign w_we    = w_idle ? we_i : r_we;
  assign w_cause = w_idle ? w_acc_cause : r_cause;
  assign w_idx   = w_idle ? addr_i[IW+1:2] : r_idx;

  assign w_to_resp = (w_idle && req_i && (LAT == 4'd0)) ||
                     ((r_state == ST_WAIT) && (r_cnt == 4'd1));

  assign w_ram_we = (r_state == ST_RESP) && r_we &&
                    (r_cause == DMEM_ERR_NONE);

  dmem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_ram_we),
    .idx_i   (w_idx),
    .wdata_i (r_wdata),
    .be_i    (r_be),
    .rdata_o (w_rd)
  );

  // Request FSM: capture, wait-state count, one-cycle registered response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_cause <= DMEM_ERR_NONE;
      r_be    <= 4'd0;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      if (w_to_resp) begin
        r_ack <= 1'b1;
        r_err <= (w_cause != DMEM_ERR_NONE);
        if (!w_we && (w_cause == DMEM_ERR_NONE)) r_rdata <= w_rd;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_idx   <= addr_i[IW+1:2];
            r_wdata <= wdata_i;
            r_cause <= w_acc_cause;
            r_be    <= w_acc_be;
            r_busy  <= 1'b1;
            r_cnt   <= LAT;
            r_state <= (LAT == 4'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd1) r_state <= ST_RESP;
          r_cnt <= r_cnt - 4'd1;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = r_busy;
  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign rdata_o = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized scoreboard bench for data_mem_responder
// (LATENCY=2 main instance) plus a LATENCY=0 instance for back-to-back timing.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = 4'hF;
  logic        busy, ack, err;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  be0 = 4'hF;
  logic        busy0, ack0, err0;
  logic [31:0] rdata0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [DEPTH];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .be_i    (be),
`endif
    .busy_o  (busy),
    .ack_o   (ack),
    .err_o   (err),
    .rdata_o (rdata)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .req_i   (req0),
    .we_i    (we0),
    .addr_i  (addr0),
    .wdata_i (wdata0),
`ifdef DMEM_BYTE_STROBE_EN
    .be_i    (be0),
`endif
    .busy_o  (busy0),
    .ack_o   (ack0),
    .err_o   (err0),
    .rdata_o (rdata0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: word RAM with error rules, applied in issue order.
  function automatic exp_t model(input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    logic [3:0] be_eff;
    int idx;
`ifdef DMEM_BYTE_STROBE_EN
    be_eff = b;
`else
    be_eff = 4'hF;
`endif
    e.err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    e.rdata = 32'd0;
    e.cyc   = 0;
    if (!e.err) begin
      idx = int'(a[31:2]);
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (be_eff[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.rdata = ref_mem[idx];
      end
    end
    return e;
  endfunction

  // Monitor: pop and compare on every ack, err must stay low otherwise.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (ack) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: ack at cycle %0d, expected none", cyc);
        end else begin
          e = sbq.pop_front();
          chk("ack_err", 32'(err), 32'(e.err));
          chk("ack_rdata", rdata, e.rdata);
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("idle_err", 32'(err), 32'd0);
      end
    end
  end

  // Issue one transaction at a negedge; returns at a negedge with busy low.
  task automatic do_txn(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input bit drop);
    exp_t e;
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy=1, expected 0 within 50 cycles");
      return;
    end
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    be = b;
    e = model(w, a, d, b);
    e.cyc = cyc + 1 + LAT;
    sbq.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop) begin
        req = 1'b0;
      end else begin
        we = 1'($urandom);
        addr = $urandom;
        wdata = $urandom;
        be = 4'($urandom);
      end
    end while (!ack && n < 50);
    if (!ack) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: ack=0, expected 1 within 50 cycles");
      sbq.delete();
    end
    @(negedge clk);
    chk("busy_after_ack", 32'(busy), 32'd0);
    req = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] v, a;
    logic [3:0] b;
    int r;

    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst0_busy", 32'(busy0), 32'd0);
    chk("rst0_ack", 32'(ack0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(1'b1, 32'h4, 32'h12345678, 4'hF, 1'b0);
    do_txn(1'b0, 32'h4, 32'h0, 4'hF, 1'b0);

    // Zero wait states, request held high across two transactions.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hCAFE0001;
    @(negedge clk);
    chk("l0_ack1", 32'(ack0), 32'd1);
    chk("l0_err1", 32'(err0), 32'd0);
    we0 = 1'b0; wdata0 = $urandom;
    @(negedge clk);
    chk("l0_gap_ack", 32'(ack0), 32'd0);
    chk("l0_gap_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    chk("l0_ack2", 32'(ack0), 32'd1);
    chk("l0_rdata", rdata0, 32'hCAFE0001);
    we0 = 1'b1; addr0 = 32'(4 * DEPTH);
    @(negedge clk);
    chk("l0_gap2_ack", 32'(ack0), 32'd0);
    @(negedge clk);
    chk("l0_oor_ack", 32'(ack0), 32'd1);
    chk("l0_oor_err", 32'(err0), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    chk("l0_busy_end", 32'(busy0), 32'd0);

    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      if (v == 32'hDEADBEEF) v = 32'h0BADF00D;
      do_txn(1'b1, 32'(4 * i), v, 4'hF, 1'b0);
    end

    // Reset in the middle of a store's wait states.
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF; be = 4'hF;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    chk("rst_mid_busy0", 32'(busy), 32'd0);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_txn(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);

    do_txn(1'b0, 32'h6, 32'h0, 4'hF, 1'b0);
    do_txn(1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, 1'b0);
    do_txn(1'b1, 32'h5, 32'hFFFFFFFF, 4'hF, 1'b0);
    do_txn(1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF, 1'b0);
    do_txn(1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
    do_txn(1'b1, 32'(4 * DEPTH - 4), 32'hA5A5F00F, 4'hF, 1'b0);
    do_txn(1'b0, 32'(4 * DEPTH - 4), 32'h0, 4'hF, 1'b0);

    do_txn(1'b1, 32'h20, 32'h600DCAFE, 4'hF, 1'b1);
    do_txn(1'b0, 32'h20, 32'h0, 4'hF, 1'b1);

`ifdef DMEM_BYTE_STROBE_EN
    do_txn(1'b1, 32'h30, 32'hAABBCCDD, 4'hF, 1'b0);
    do_txn(1'b1, 32'h30, 32'h11223344, 4'b0101, 1'b0);
    do_txn(1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
    do_txn(1'b1, 32'h30, 32'h55555555, 4'b0000, 1'b0);
    do_txn(1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
`endif

    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r < 7)
        a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (r == 7)
        a = {22'd0, 8'($urandom_range(0, DEPTH - 1)),
             2'($urandom_range(1, 3))};
      else if (r == 8)
        a = 32'(4 * DEPTH + 4 * $urandom_range(0, 1000));
      else
        a = $urandom;
`ifdef DMEM_BYTE_STROBE_EN
      b = 4'($urandom);
`else
      b = 4'hF;
`endif
      do_txn(1'($urandom), a, $urandom, b, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
